// File: rtl/morse_tx.sv
// Morse transmitter: keys one output with the international Morse pattern of
// letter A..Z using dot=1, dash=3, intra-space=1 and letter gap=3 unit timing.
module morse_tx #(
  parameter int unsigned UNIT_CYCLES = 25000000
) (
  input  logic       i_CLOCK_50,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [4:0] i_letter,
  input  logic       i_repeat,
  input  logic       i_abort,
  output logic       o_out,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned UCW = $clog2(UNIT_CYCLES + 1);
  localparam logic [UCW-1:0] CNT_MAX = UCW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  state_t         r_state, w_next;
  logic [UCW-1:0] r_cnt;
  logic [1:0]     r_units;
  logic [4:0]     r_letter;
  logic [1:0]     r_last;
  logic [3:0]     r_sym;
  logic [1:0]     r_idx;
  logic           r_out, r_busy, r_done, r_err;

  logic [4:0]     w_rom_sel;
  logic [5:0]     w_rom;
  logic [1:0]     w_need;
  logic [1:0]     w_bitpos;
  logic           w_tick, w_phase_end, w_valid, w_done, w_err;

  // ROM is addressed by the live input in IDLE and by the latched letter on repeat
  assign w_rom_sel = (r_state == IDLE) ? i_letter : r_letter;

  // {len-1, symbols left-aligned MSB first, 1=dash}
  always_comb begin
    w_rom = '0;
    case (w_rom_sel)
      5'd0:  w_rom = {2'd1, 4'b0100}; // A .-
      5'd1:  w_rom = {2'd3, 4'b1000}; // B -...
      5'd2:  w_rom = {2'd3, 4'b1010}; // C -.-.
      5'd3:  w_rom = {2'd2, 4'b1000}; // D -..
      5'd4:  w_rom = {2'd0, 4'b0000}; // E .
      5'd5:  w_rom = {2'd3, 4'b0010}; // F ..-.
      5'd6:  w_rom = {2'd2, 4'b1100}; // G --.
      5'd7:  w_rom = {2'd3, 4'b0000}; // H ....
      5'd8:  w_rom = {2'd1, 4'b0000}; // I ..
      5'd9:  w_rom = {2'd3, 4'b0111}; // J .---
      5'd10: w_rom = {2'd2, 4'b1010}; // K -.-
      5'd11: w_rom = {2'd3, 4'b0100}; // L .-..
      5'd12: w_rom = {2'd1, 4'b1100}; // M --
      5'd13: w_rom = {2'd1, 4'b1000}; // N -.
      5'd14: w_rom = {2'd2, 4'b1110}; // O ---
      5'd15: w_rom = {2'd3, 4'b0110}; // P .--.
      5'd16: w_rom = {2'd3, 4'b1101}; // Q --.-
      5'd17: w_rom = {2'd2, 4'b0100}; // R .-.
      5'd18: w_rom = {2'd2, 4'b0000}; // S ...
      5'd19: w_rom = {2'd0, 4'b1000}; // T -
      5'd20: w_rom = {2'd2, 4'b0010}; // U ..-
      5'd21: w_rom = {2'd3, 4'b0001}; // V ...-
      5'd22: w_rom = {2'd2, 4'b0110}; // W .--
      5'd23: w_rom = {2'd3, 4'b1001}; // X -..-
      5'd24: w_rom = {2'd3, 4'b1011}; // Y -.--
      5'd25: w_rom = {2'd3, 4'b1100}; // Z --..
      default: w_rom = '0;
    endcase
  end

  assign w_valid  = (i_letter < 5'd26);
  assign w_bitpos = 2'd3 - r_idx;
  assign w_tick   = (r_cnt == CNT_MAX);

  // Units still owed in the current phase, minus one
  always_comb begin
    w_need = 2'd0;
    case (r_state)
      MARK:    w_need = r_sym[w_bitpos] ? 2'd2 : 2'd0;
      GAP:     w_need = 2'd2;
      default: w_need = 2'd0;
    endcase
  end

  assign w_phase_end = w_tick && (r_units == w_need);

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_valid) w_next = MARK;
          else         w_err  = 1'b1;
        end
      end
      MARK:  if (w_phase_end) w_next = (r_idx == r_last) ? GAP : SPACE;
      SPACE: if (w_phase_end) w_next = MARK;
      GAP: begin
        if (w_phase_end) begin
          if (i_repeat) begin
            w_next = MARK;
          end else begin
            w_next = IDLE;
            w_done = 1'b1;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE && i_abort) begin
      w_next = IDLE;
      w_done = 1'b0;
    end
  end

  always_ff @(posedge i_CLOCK_50 or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_units  <= '0;
      r_letter <= '0;
      r_last   <= '0;
      r_sym    <= '0;
      r_idx    <= '0;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == MARK);
      r_busy  <= (w_next != IDLE);
      r_done  <= w_done;
      r_err   <= w_err;

      if (r_state == IDLE && w_next == MARK) begin
        r_letter <= i_letter;
        r_last   <= w_rom[5:4];
        r_sym    <= w_rom[3:0];
        r_idx    <= '0;
      end else if (r_state == GAP && w_next == MARK) begin
        r_last <= w_rom[5:4];
        r_sym  <= w_rom[3:0];
        r_idx  <= '0;
      end else if (r_state == SPACE && w_next == MARK) begin
        r_idx <= r_idx + 2'd1;
      end

      // Every phase boundary is a state change, so reload on change keeps phases exact
      if (r_state == IDLE || w_next != r_state) begin
        r_cnt   <= '0;
        r_units <= '0;
      end else if (w_tick) begin
        r_cnt   <= '0;
        r_units <= r_units + 2'd1;
      end else begin
        r_cnt <= r_cnt + UCW'(1);
      end
    end
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

endmodule
